// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the multiply/divide sequencer state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. One shift-add or
// restoring shift-subtract step per cycle on a shared 2*XLEN accumulator;
// signs are stripped on entry and restored when the result is captured.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  muldiv_state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_q, neg_rem_q, div0_q, ovf_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              accept, last_step, finish;
  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   div_diff;

  // Restore signs on the unsigned accumulator and patch the divide corner cases.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [2:0]        f3,
    input logic [2*XLEN-1:0] acc,
    input logic              neg,
    input logic              neg_rem,
    input logic              div0,
    input logic              ovf
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r, res;
    prod = neg ? -acc : acc;
    q    = acc[XLEN-1:0];
    r    = acc[2*XLEN-1:XLEN];
    if (!f3[2]) begin
      res = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (f3[1]) begin
      res = ovf ? '0 : (neg_rem ? -r : r);
    end else if (div0) begin
      res = '1;
    end else if (ovf) begin
      res = {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      res = neg ? -q : q;
    end
    return res;
  endfunction

  assign accept    = (state_q == IDLE) && start && !flush;
  assign last_step = (cnt_q == CNT_W'(XLEN-1));
  assign finish    = (state_q == CALC) && last_step && !flush;

  // Operand decode: which operands are signed, and their magnitudes.
  always_comb begin
    a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa       = a_signed && op_a[XLEN-1];
    sb       = b_signed && op_b[XLEN-1];
    a_mag    = sa ? -op_a : op_a;
    b_mag    = sb ? -op_b : op_b;
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (!f3_q[2]) begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end else if (!div_diff[XLEN+1]) begin
      acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Next-state logic and the combinational stall request.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        stall   = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Control and visible outputs: counter, done pulse, captured result and rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish) begin
        result_q <= fix_result(f3_q, acc_d, neg_q, neg_rem_q, div0_q, ovf_q);
        rd_out_q <= rd_q;
      end
    end
  end

  // Operation context and accumulator; only meaningful while an op is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q      <= funct3;
      rd_q      <= rd_in;
      neg_q     <= sa ^ sb;
      neg_rem_q <= sa;
      div0_q    <= funct3[2] && (op_b == '0);
      ovf_q     <= (funct3 == F3_DIV || funct3 == F3_REM) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      opnd_q    <= funct3[2] ? b_mag : a_mag;
      acc_q     <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: the driver pushes expected results
// from an arithmetic reference model; a monitor checks each done pulse.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passes = 0;
  int   stall_run = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  // Present an op as ID/EX would: held while stall is high, released after the done cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input bit hold);
    bit ok;
    exp_t e;
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      e.res = model(f3, a, b); e.rd = rd; e.at = cyc + 32;
      exp_q.push_back(e);
    end
    if (hold) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!stall) begin ok = 1'b1; break; end
      end
      chk("stall_release_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_run = 0;
    end else begin
      if (stall) stall_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("rd_out", 32'(rd_out), 32'(e.rd));
          chk("done_cycle", cyc, e.at);
          chk("stall_cycles", stall_run, 33);
          chk("stall_in_done", 32'(stall), 32'd0);
        end
        stall_run = 0;
      end
      if (flush) stall_run = 0;
    end
  end

  initial begin
    bit drained;
    rst = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", 32'(rd_out), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases, back to back.
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1, 1);
    issue(3'd1, 32'h80000000, 32'h80000000, 5'd6, 1, 1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1, 1);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1, 1);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd9, 1, 1);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd10, 1, 1);
    issue(3'd5, 32'd100, 32'd7, 5'd11, 1, 1);
    issue(3'd7, 32'd100, 32'd7, 5'd12, 1, 1);
    issue(3'd4, 32'd1234, 32'd0, 5'd13, 1, 1);
    issue(3'd7, 32'd5, 32'd0, 5'd14, 1, 1);
    issue(3'd6, 32'hFFFFFF00, 32'd0, 5'd15, 1, 1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1, 1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17, 1, 1);

    // Flush ten cycles into a DIV: no done, then a fresh MUL completes normally.
    issue(3'd4, 32'd1000, 32'd3, 5'd18, 0, 0);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("stall_after_flush", 32'(stall), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(3'd0, 32'd3, 32'd4, 5'd19, 1, 1);

    // Reset twenty cycles into a MUL clears all outputs.
    issue(3'd0, 32'd55, 32'd66, 5'd20, 0, 0);
    repeat (19) @(posedge clk);
    #1; rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1, 1);
    end

    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) begin drained = 1'b1; break; end
      @(posedge clk);
    end
    chk("scoreboard_drained", 32'(drained), 32'd1);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
